// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: rotates active-low row strobes, synchronizes and
// debounces the column returns, and emits one key_valid pulse per clean press.
module keypad_scan_debounce #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] C,
  output logic [3:0] R,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_PRESSED} state_t;

  state_t          state_q, state_d;
  logic [3:0]      c_meta_q, c_sync_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      row_q, row_d, col_q, col_d;
  logic [3:0]      match_q, match_d, rel_q, rel_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d, held_q, held_d;

  logic            sample;
  logic            c_ok;
  logic [1:0]      c_idx;
  logic [3:0]      pat;
  logic [3:0]      match_inc, rel_inc;

  // Exactly one column low is a usable pattern; anything else reads as no key.
  always_comb begin
    c_ok  = 1'b1;
    c_idx = 2'd0;
    case (c_sync_q)
      4'b1110: c_idx = 2'd0;
      4'b1101: c_idx = 2'd1;
      4'b1011: c_idx = 2'd2;
      4'b0111: c_idx = 2'd3;
      default: c_ok  = 1'b0;
    endcase
  end

  assign sample    = (dwell_q == DWELL_LAST);
  assign pat       = ~(4'b0001 << col_q);
  assign match_inc = (match_q >= DB) ? match_q : match_q + 4'd1;
  assign rel_inc   = (rel_q   >= DB) ? rel_q   : rel_q   + 4'd1;

  always_comb begin
    state_d = state_q;
    dwell_d = sample ? '0 : dwell_q + DW'(1);
    row_d   = row_q;
    col_d   = col_q;
    match_d = match_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (c_ok) begin
            col_d   = c_idx;
            match_d = 4'd1;
            if (DB <= 4'd1) begin
              valid_d = 1'b1;
              held_d  = 1'b1;
              code_d  = {row_q, c_idx};
              rel_d   = '0;
              state_d = ST_PRESSED;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (c_sync_q == pat) begin
            match_d = match_inc;
            if (match_inc >= DB) begin
              valid_d = 1'b1;
              held_d  = 1'b1;
              code_d  = {row_q, col_q};
              rel_d   = '0;
              state_d = ST_PRESSED;
            end
          end else begin
            match_d = '0;
            row_d   = row_q + 2'd1;
            state_d = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          // Any other key still down keeps the release count from building.
          if (c_sync_q == 4'hF) begin
            rel_d = rel_inc;
            if (rel_inc >= DB) begin
              held_d  = 1'b0;
              rel_d   = '0;
              match_d = '0;
              row_d   = row_q + 2'd1;
              state_d = ST_SCAN;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SCAN;
      c_meta_q <= 4'hF;
      c_sync_q <= 4'hF;
      dwell_q  <= '0;
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      match_q  <= '0;
      rel_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_meta_q <= C;
      c_sync_q <= c_meta_q;
      dwell_q  <= dwell_d;
      row_q    <= row_d;
      col_q    <= col_d;
      match_q  <= match_d;
      rel_q    <= rel_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      held_q   <= held_d;
    end
  end

  assign R         = ~(4'b0001 << row_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad model drives C from R; a sample-level
// reference model is checked every cycle, plus table vectors and corner sequences.
module tb_keypad_scan_debounce;
  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  C, R, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys;

  int n_cmp = 0, n_bad = 0, pulses = 0;

  // reference model state (mode: 0 scanning, 1 confirming, 2 held)
  int         m_ph, m_row, m_mode, m_cnt, m_col;
  logic [3:0] m_s1, m_s2, m_code;
  logic       m_valid, m_held;

  always #5 clk = ~clk;

  // keypad: a pressed key at (r,c) pulls column c low while row r is strobed
  always_comb begin
    C = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !R[r]) C[c] = 1'b0;
  end

  keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk), .rst(rst), .C(C), .R(R),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_ph = 0; m_row = 0; m_mode = 0; m_cnt = 0; m_col = 0;
    m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_valid = 1'b0; m_held = 1'b0;
  endfunction

  function automatic void model_accept();
    m_valid = 1'b1;
    m_held  = 1'b1;
    m_code  = 4'(m_row * 4 + m_col);
    m_mode  = 2;
    m_cnt   = 0;
  endfunction

  // One clock: a sample is taken once per row dwell, on its final cycle,
  // seeing the column value from two clocks earlier.
  function automatic void model_step(input logic [3:0] c);
    logic [3:0] smp, pat;
    int n_low, col;
    smp = m_s2;
    m_valid = 1'b0;
    if (m_ph == SD - 1) begin
      n_low = 0; col = 0;
      for (int b = 0; b < 4; b++) if (!smp[b]) begin n_low++; col = b; end
      pat = 4'hF; pat[m_col] = 1'b0;
      case (m_mode)
        0: if (n_low == 1) begin
             m_col = col; m_cnt = 1;
             if (m_cnt >= DB) model_accept(); else m_mode = 1;
           end else m_row = (m_row + 1) % 4;
        1: if (smp == pat) begin
             m_cnt++;
             if (m_cnt >= DB) model_accept();
           end else begin
             m_mode = 0; m_cnt = 0; m_row = (m_row + 1) % 4;
           end
        default: if (smp == 4'hF) begin
             m_cnt++;
             if (m_cnt >= DB) begin m_held = 1'b0; m_mode = 0; m_cnt = 0; m_row = (m_row + 1) % 4; end
           end else m_cnt = 0;
      endcase
    end
    m_s2 = m_s1;
    m_s1 = c;
    m_ph = (m_ph + 1) % SD;
  endfunction

  // Called at a negedge; returns at the next negedge after comparing.
  task automatic tick();
    logic [3:0] cp, er;
    #1 cp = C;
    @(posedge clk);
    if (!rst) model_step(cp);
    @(negedge clk);
    er = 4'hF; er[m_row] = 1'b0;
    chk("R", R, er);
    chk("key_valid", key_valid, m_valid);
    chk("key_held", key_held, m_held);
    chk("key_code", key_code, m_code);
    if (key_valid) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    logic [15:0] k;
    int          hold;
    int          exp_pulses;
    logic [3:0]  exp_code;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [3:0] er;
    bit ok;
    tbl[0] = '{16'h0200, 60, 1, 4'h9};  // row2/col1
    tbl[1] = '{16'h0001, 60, 1, 4'h0};
    tbl[2] = '{16'h8000, 60, 1, 4'hF};
    tbl[3] = '{16'h0040, 60, 1, 4'h6};
    tbl[4] = '{16'h0090, 60, 0, 4'h0};  // two keys on row1

    keys = '0;
    rst  = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_R", R, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_code", key_code, 0);
    rst = 1'b0;

    // idle rotation, 4 clocks per row
    pulses = 0;
    for (int i = 0; i < 32; i++) begin
      tick();
      er = 4'hF; er[((i + 1) / SD) % 4] = 1'b0;
      chk("idle_R", R, er);
    end
    chk("idle_pulses", pulses, 0);

    // table vectors
    for (int t = 0; t < 5; t++) begin
      pulses = 0;
      keys = tbl[t].k;
      ticks(tbl[t].hold);
      chk("tbl_held_during", key_held, tbl[t].exp_pulses != 0);
      keys = '0;
      ticks(40);
      chk("tbl_pulses", pulses, tbl[t].exp_pulses);
      if (tbl[t].exp_pulses != 0) chk("tbl_code", key_code, tbl[t].exp_code);
      chk("tbl_released", key_held, 0);
    end

    // bounce: row0/col3 visible for a single sample only
    pulses = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (m_row == 0 && m_ph == 0 && m_mode == 0);
    end
    chk("bounce_align", ok, 1);
    keys = 16'h0008;
    ticks(4);
    keys = '0;
    ticks(4);
    chk("bounce_R", R, 4'b1101);
    ticks(8);
    chk("bounce_pulses", pulses, 0);

    // short release then re-press: one pulse; full release then press: second
    pulses = 0;
    keys = 16'h0002;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin tick(); ok = key_held; end
    chk("k1_held", ok, 1);
    keys = '0;      ticks(8);
    keys = 16'h0002; ticks(20);
    chk("k1_one_pulse", pulses, 1);
    chk("k1_still_held", key_held, 1);
    keys = '0;      ticks(40);
    keys = 16'h0002; ticks(60);
    chk("k1_two_pulses", pulses, 2);
    chk("k1_code", key_code, 4'h1);
    keys = '0;      ticks(40);

    // reset while held
    keys = 16'h0400;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin tick(); ok = key_held; end
    chk("rstA_held", ok, 1);
    rst = 1'b1; keys = '0;
    #1;
    chk("rstA_R", R, 4'b1110);
    chk("rstA_held0", key_held, 0);
    chk("rstA_code", key_code, 0);
    model_reset();
    ticks(2);
    rst = 1'b0;
    tick();
    chk("rstA_restart", R, 4'b1110);

    // reset one cycle before the pulse
    pulses = 0;
    keys = 16'h2000;
    ok = 0;
    for (int i = 0; i < 80 && !ok; i++) begin
      tick();
      ok = (m_mode == 1 && m_cnt == DB - 1 && m_ph == SD - 1);
    end
    chk("rstB_align", ok, 1);
    rst = 1'b1; keys = '0;
    #1;
    chk("rstB_valid", key_valid, 0);
    chk("rstB_R", R, 4'b1110);
    model_reset();
    ticks(2);
    rst = 1'b0;
    ticks(3);
    chk("rstB_restart", R, 4'b1110);
    ticks(20);
    chk("rstB_pulses", pulses, 0);

    // randomized presses against the model
    for (int it = 0; it < 30; it++) begin
      int k;
      k = $urandom_range(0, 17);
      if (k < 16)       keys = 16'(1) << k;
      else if (k == 16) keys = 16'($urandom);
      else              keys = '0;
      ticks($urandom_range(1, 60));
      keys = '0;
      ticks($urandom_range(0, 40));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, limit %0d", 2000000);
    $fatal(1);
  end
endmodule
